// File: rtl/ctrl_decode_stage.sv
// ---------------------------------------------------------------------------
// ctrl_decode_stage
//   Single-entry registered decode stage for a two-slot instruction bundle.
//   Slot 1 (ALU) and slot 2 (mem/branch) opcodes are decoded into a control
//   word. The word is held in one output register with a valid/ready
//   handshake. Bundles that contain an invalid opcode are squashed and never
//   emitted. The first such fault is captured in sticky exception registers.
//
//   Optional feature: define CTRL_DECODE_INV_COUNT_EN to build the saturating
//   invalid-bundle counter. Without it, inv_count is tied to 0.
//
// Ports
//   clk, reset                clock (rising edge), async active-high reset
//   in_valid / in_ready       upstream handshake (in_ready is combinational)
//   opcode1[6:0], opcode2[4:0] slot-1 / slot-2 opcodes
//   pc[PC_W-1:0]              bundle PC, kept only when a fault is captured
//   flush                     empties the stage and drops a same-cycle bundle
//   out_valid / out_ready     downstream handshake
//   regWrite1, g1DstReg, flagWrite1, aluSrc1, aluSrc2, aluOp   slot-1 controls
//   regWrite2, flagWrite2, memRd, memWr, branch, jump          slot-2 controls
//   exc_valid, exc_cause, exc_pc, exc_clear   sticky fault capture and clear
//   inv_count[CNT_W-1:0]      saturating count of accepted invalid bundles
// ---------------------------------------------------------------------------
module ctrl_decode_stage #(
   parameter int PC_W  = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       opcode1,
   input  logic [4:0]       opcode2,
   input  logic [PC_W-1:0]  pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             regWrite1,
   output logic             g1DstReg,
   output logic             flagWrite1,
   output logic [1:0]       aluSrc1,
   output logic [1:0]       aluSrc2,
   output logic [1:0]       aluOp,
   output logic             regWrite2,
   output logic             flagWrite2,
   output logic             memRd,
   output logic             memWr,
   output logic             branch,
   output logic             jump,
   output logic             exc_valid,
   output logic [1:0]       exc_cause,
   output logic [PC_W-1:0]  exc_pc,
   input  logic             exc_clear,
   output logic [CNT_W-1:0] inv_count
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t          state_q;
   logic [8:0]      s1_word;   // {rw1, fw1, g1, src1, src2, op}
   logic            s1_ok;
   logic [5:0]      s2_word;   // {rw2, fw2, memRd, memWr, branch, jump}
   logic            s2_ok;
   logic [14:0]     ctrl_q;
   logic            exc_valid_q;
   logic [1:0]      exc_cause_q;
   logic [PC_W-1:0] exc_pc_q;
   logic            accept;
   logic            fault;

   // Slot-1 decode keys on opcode1[6:2]; the low bits only qualify cmp/shift.
   always_comb begin
      s1_ok   = 1'b1;
      s1_word = '0;
      case (opcode1[6:2])
         5'b00100: s1_word = {1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00};
         5'b00011: s1_word = {1'b1, 1'b1, 1'b1, 2'b01, 2'b00, 2'b01};
         5'b01000: s1_word = {(opcode1[1:0] == 2'b01), 1'b1, 1'b1, 2'b10, 2'b01, 2'b10};
         5'b00000: s1_word = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11};
         default:  s1_ok   = 1'b0;
      endcase
   end

   always_comb begin
      s2_ok   = 1'b1;
      s2_word = '0;
      case (opcode2)
         5'b10001: s2_word = 6'b111000;
         5'b10000: s2_word = 6'b000100;
         5'b11100: s2_word = 6'b000001;
         5'b11010: s2_word = 6'b000010;
         5'b00000: s2_word = 6'b000000;
         default:  s2_ok   = 1'b0;
      endcase
   end

   // out_valid is 0 throughout reset, so in_ready reads 1 there while the
   // asynchronous reset keeps any bundle from being registered.
   assign in_ready = (state_q == EMPTY) || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   assign fault    = accept && !(s1_ok && s2_ok);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= EMPTY;
         ctrl_q      <= '0;
         exc_valid_q <= 1'b0;
         exc_cause_q <= 2'b00;
         exc_pc_q    <= '0;
      end else begin
         // Word register: flush wins, then a clean accept, then a drain.
         // Otherwise hold (stalled FULL, or idle EMPTY already at zero).
         if (flush) begin
            state_q <= EMPTY;
            ctrl_q  <= '0;
         end else if (accept && !fault) begin
            state_q <= FULL;
            ctrl_q  <= {s1_word, s2_word};
         end else if (out_ready) begin
            state_q <= EMPTY;
            ctrl_q  <= '0;
         end

         // A fault arriving with exc_clear replaces the old one, so the
         // sticky flag never drops in that cycle.
         if (fault && (!exc_valid_q || exc_clear)) begin
            exc_valid_q <= 1'b1;
            exc_cause_q <= {!s2_ok, !s1_ok};
            exc_pc_q    <= pc;
         end else if (exc_clear) begin
            exc_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = (state_q == FULL);
   assign {regWrite1, flagWrite1, g1DstReg, aluSrc1, aluSrc2, aluOp,
           regWrite2, flagWrite2, memRd, memWr, branch, jump} = ctrl_q;
   assign exc_valid = exc_valid_q;
   assign exc_cause = exc_cause_q;
   assign exc_pc    = exc_pc_q;

`ifdef CTRL_DECODE_INV_COUNT_EN
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (fault && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign inv_count = cnt_q;
`else
   assign inv_count = '0;
`endif

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench for ctrl_decode_stage: a cycle model derived from the
// decode tables and handshake rules, compared on every falling edge, plus
// hand-computed literal checks at key points of a directed sequence.
module tb_ctrl_decode_stage;
   localparam int PC_W  = 16;
   localparam int CNT_W = 2;

`ifdef CTRL_DECODE_INV_COUNT_EN
   localparam logic [CNT_W-1:0] CNT_AFTER2 = 2'd2;
   localparam logic [CNT_W-1:0] CNT_SAT    = 2'd3;
`else
   localparam logic [CNT_W-1:0] CNT_AFTER2 = 2'd0;
   localparam logic [CNT_W-1:0] CNT_SAT    = 2'd0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, exc_clear = 1'b0;
   logic [6:0] opcode1 = '0;
   logic [4:0] opcode2 = '0;
   logic [PC_W-1:0] pc = '0;
   logic in_ready, out_valid;
   logic regWrite1, g1DstReg, flagWrite1, regWrite2, flagWrite2;
   logic memRd, memWr, branch, jump, exc_valid;
   logic [1:0] aluSrc1, aluSrc2, aluOp, exc_cause;
   logic [PC_W-1:0] exc_pc;
   logic [CNT_W-1:0] inv_count;

   int n_vec  = 0;
   int n_miss = 0;

   ctrl_decode_stage #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .opcode1(opcode1), .opcode2(opcode2), .pc(pc), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .regWrite1(regWrite1), .g1DstReg(g1DstReg), .flagWrite1(flagWrite1),
      .aluSrc1(aluSrc1), .aluSrc2(aluSrc2), .aluOp(aluOp),
      .regWrite2(regWrite2), .flagWrite2(flagWrite2), .memRd(memRd),
      .memWr(memWr), .branch(branch), .jump(jump),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc),
      .exc_clear(exc_clear), .inv_count(inv_count)
   );

   always #5 clk = ~clk;

   // Observed control word: {out_valid, rw1, fw1, g1, src1, src2, op, rw2, fw2, memRd, memWr, branch, jump}
   logic [15:0] act_ctrl;
   assign act_ctrl = {out_valid, regWrite1, flagWrite1, g1DstReg, aluSrc1, aluSrc2,
                      aluOp, regWrite2, flagWrite2, memRd, memWr, branch, jump};

   // ---------------- behavioural model ----------------
   logic            m_full;
   logic [14:0]     m_word;
   logic            m_exc;
   logic [1:0]      m_cause;
   logic [PC_W-1:0] m_pc;
   logic [CNT_W-1:0] m_cnt;

   logic       t_ok1, t_ok2, t_acc;
   logic [8:0] t_w1;
   logic [5:0] t_w2;

   // Decode tables in {rw1,fw1,g1,src1,src2,op} / {rw2,fw2,memRd,memWr,branch,jump} order.
   always_comb begin
      t_ok1 = 1'b1;
      t_w1  = '0;
      t_ok2 = 1'b1;
      t_w2  = '0;
      if      (opcode1[6:2] == 5'b00100) t_w1 = 9'b1_1_0_00_10_00;
      else if (opcode1[6:2] == 5'b00011) t_w1 = 9'b1_1_1_01_00_01;
      else if (opcode1[6:2] == 5'b01000) t_w1 = (opcode1[1:0] == 2'b01) ? 9'b1_1_1_10_01_10
                                                                        : 9'b0_1_1_10_01_10;
      else if (opcode1[6:2] == 5'b00000) t_w1 = 9'b0_0_0_00_00_11;
      else t_ok1 = 1'b0;
      if      (opcode2 == 5'b10001) t_w2 = 6'b111000;
      else if (opcode2 == 5'b10000) t_w2 = 6'b000100;
      else if (opcode2 == 5'b11100) t_w2 = 6'b000001;
      else if (opcode2 == 5'b11010) t_w2 = 6'b000010;
      else if (opcode2 == 5'b00000) t_w2 = 6'b000000;
      else t_ok2 = 1'b0;
      t_acc = in_valid && (!m_full || out_ready) && !flush;
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_full <= 1'b0; m_word <= '0; m_exc <= 1'b0;
         m_cause <= '0; m_pc <= '0; m_cnt <= '0;
      end else begin
         // Occupancy after the edge: loaded by a clean accept, kept only while stalled.
         m_full <= !flush && ((t_acc && t_ok1 && t_ok2) || (m_full && !out_ready));
         if (flush)                        m_word <= '0;
         else if (t_acc && t_ok1 && t_ok2) m_word <= {t_w1, t_w2};
         else if (!(m_full && !out_ready)) m_word <= '0;
         if (t_acc && !(t_ok1 && t_ok2)) begin
            if (!m_exc || exc_clear) begin
               m_exc <= 1'b1; m_cause <= {!t_ok2, !t_ok1}; m_pc <= pc;
            end else if (exc_clear) m_exc <= 1'b0;
`ifdef CTRL_DECODE_INV_COUNT_EN
            if (m_cnt != {CNT_W{1'b1}}) m_cnt <= m_cnt + 1'b1;
`endif
         end else if (exc_clear) m_exc <= 1'b0;
      end
   end

   // Cycle compare on the falling edge.
   always @(negedge clk) begin
      logic [37:0] act, exp;
      act = {act_ctrl, in_ready, exc_valid, exc_cause, exc_pc, inv_count};
      exp = {m_full, m_word, (!m_full || out_ready), m_exc, m_cause, m_pc, m_cnt};
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL cycle_cmp t=%0t: got %h expected %h", $time, act, exp);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic iv, input logic [6:0] o1, input logic [4:0] o2,
                        input logic [15:0] p, input logic fl, input logic ordy, input logic clr);
      in_valid = iv; opcode1 = o1; opcode2 = o2; pc = p;
      flush = fl; out_ready = ordy; exc_clear = clr;
      @(posedge clk); #2;
      $display("txn v=%0b op1=%b op2=%b pc=%h fl=%0b rdy=%0b clr=%0b -> ov=%0b exc=%0b/%b/%h cnt=%0d",
               iv, o1, o2, p, fl, ordy, clr, out_valid, exc_valid, exc_cause, exc_pc, inv_count);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] held;
      #1 reset = 1'b1;
      // Valid bundle offered during reset must not be taken.
      in_valid = 1'b1; opcode1 = 7'b0010000; opcode2 = 5'b10001; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      check("reset_ctrl", 40'(act_ctrl), 40'h0);
      check("reset_in_ready", 40'(in_ready), 40'h1);
      in_valid = 1'b0; reset = 1'b0;
      drive(0, 7'b0, 5'b0, 16'h0, 0, 1, 0);
      check("post_reset_empty", 40'(act_ctrl), 40'h0);

      // add + load
      drive(1, 7'b0010000, 5'b10001, 16'h0010, 0, 1, 0);
      check("add_load", 40'(act_ctrl), 40'({1'b1, 9'b1_1_0_00_10_00, 6'b111000}));
      // back-to-back sub + store
      drive(1, 7'b0001100, 5'b10000, 16'h0012, 0, 1, 0);
      check("sub_store", 40'(act_ctrl), 40'({1'b1, 9'b1_1_1_01_00_01, 6'b000100}));
      // cmp with rw1, jump
      drive(1, 7'b0100001, 5'b11100, 16'h0014, 0, 1, 0);
      check("cmp_rw_jump", 40'(act_ctrl), 40'({1'b1, 9'b1_1_1_10_01_10, 6'b000001}));
      // cmp without rw1, branch; accepted with out_ready=1, then stalled
      drive(1, 7'b0100010, 5'b11010, 16'h0016, 0, 1, 0);
      check("cmp_norw_branch", 40'(act_ctrl), 40'({1'b1, 9'b0_1_1_10_01_10, 6'b000010}));
      held = act_ctrl;

      // Hold three cycles with a pending nop bundle.
      for (int i = 0; i < 3; i++) begin
         drive(1, 7'b0000000, 5'b00000, 16'h0018, 0, 0, 0);
         check("hold_ctrl", 40'(act_ctrl), 40'(16'({1'b1, 9'b0_1_1_10_01_10, 6'b000010})));
         check("hold_in_ready", 40'(in_ready), 40'h0);
      end
      drive(1, 7'b0000000, 5'b00000, 16'h0018, 0, 1, 0);
      check("release_nop", 40'(act_ctrl), 40'({1'b1, 9'b0_0_0_00_00_11, 6'b000000}));
      drive(0, 7'b0, 5'b0, 16'h0, 0, 1, 0);
      check("drain_zero", 40'(act_ctrl), 40'h0);

      // Faults: slot1 invalid, then slot2 invalid.
      drive(1, 7'b1111100, 5'b00000, 16'h0040, 0, 1, 0);
      check("fault1_exc", 40'({out_valid, exc_valid, exc_cause, exc_pc}), 40'({1'b0, 1'b1, 2'b01, 16'h0040}));
      drive(1, 7'b0000000, 5'b01010, 16'h0044, 0, 1, 0);
      check("fault2_exc", 40'({out_valid, exc_valid, exc_cause, exc_pc}), 40'({1'b0, 1'b1, 2'b01, 16'h0040}));
      check("fault2_count", 40'(inv_count), 40'(CNT_AFTER2));

      // Invalid bundle accepted while FULL drains the stage.
      drive(1, 7'b0010000, 5'b00000, 16'h0046, 0, 1, 0);
      drive(1, 7'b1111100, 5'b00000, 16'h0048, 0, 1, 0);
      check("fault_full_drain", 40'({out_valid, exc_pc}), 40'({1'b0, 16'h0040}));

      // Clear together with a both-invalid fault.
      drive(1, 7'b1111100, 5'b01010, 16'h0050, 0, 1, 1);
      check("clear_newfault", 40'({exc_valid, exc_cause, exc_pc}), 40'({1'b1, 2'b11, 16'h0050}));
      drive(0, 7'b0, 5'b0, 16'h0, 0, 1, 1);
      check("plain_clear", 40'(exc_valid), 40'h0);

      // Flush with a same-cycle valid bundle while FULL.
      drive(1, 7'b0010000, 5'b10001, 16'h0060, 0, 1, 0);
      drive(1, 7'b0001100, 5'b10000, 16'h0062, 1, 1, 0);
      check("flush_empty", 40'(act_ctrl), 40'h0);
      drive(0, 7'b0, 5'b0, 16'h0, 0, 1, 0);
      check("flush_dropped", 40'(out_valid), 40'h0);

      // Fifth fault: CNT_W=2 saturates at 3.
      drive(1, 7'b0000000, 5'b11111, 16'h0070, 0, 1, 0);
      check("count_saturate", 40'(inv_count), 40'(CNT_SAT));

      // Reset while FULL and stalled.
      drive(1, 7'b0010000, 5'b10001, 16'h0080, 0, 0, 0);
      drive(1, 7'b0001100, 5'b10000, 16'h0082, 0, 0, 0);
      check("stalled_full", 40'(out_valid), 40'h1);
      #1 reset = 1'b1;
      #1;
      check("async_reset_outputs", 40'({act_ctrl, exc_valid, exc_cause, exc_pc, inv_count}), 40'h0);
      check("async_reset_in_ready", 40'(in_ready), 40'h1);
      @(posedge clk); #2;
      in_valid = 1'b0; reset = 1'b0;
      drive(0, 7'b0, 5'b0, 16'h0, 0, 1, 0);
      check("reset_discard", 40'(act_ctrl), 40'h0);
      if (held == 16'h0) check("held_nonzero", 40'(held), 40'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
